// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified memory port between instruction fetch (port A, read-only)
// and the MEM stage (port B, read/write). One transaction is in flight at a time.
// B is the older instruction and wins ties, but a streak counter caps how many
// contested B grants may go by before A is forced through.
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MAX_B_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                read_a,
    input  logic [ADDR_W-1:0]   address_a,
    output logic                resp_a,
    output logic [DATA_W-1:0]   rdata_a,

    input  logic                read_b,
    input  logic                write_b,
    input  logic [ADDR_W-1:0]   address_b,
    input  logic [DATA_W-1:0]   wdata_b,
    input  logic [DATA_W/8-1:0] wmask_b,
    output logic                resp_b,
    output logic [DATA_W-1:0]   rdata_b,

    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                grant_a,
    output logic                grant_b
);

    localparam int MASK_W = DATA_W / 8;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_B_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_A = 2'd1,
        ST_SERVE_B = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] streak_q, streak_d;

    logic req_a;
    logic req_b;

    assign req_a = read_a;
    assign req_b = read_b | write_b;

    // Tie-break: B wins unless it has already won STREAK_MAX contested rounds.
    // The caller masks out the requester that was just served.
    function automatic state_t pick(input logic ra, input logic rb, input logic [3:0] streak);
        state_t nxt;
        if (ra && rb) begin
            nxt = (streak == STREAK_MAX) ? ST_SERVE_A : ST_SERVE_B;
        end else if (ra) begin
            nxt = ST_SERVE_A;
        end else if (rb) begin
            nxt = ST_SERVE_B;
        end else begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

    // Next-state and streak update; a served requester is excluded on its own
    // completion cycle because its request is still high then.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        case (state_q)
            ST_IDLE: begin
                state_d = pick(req_a, req_b, streak_q);
            end
            ST_SERVE_A: begin
                if (mem_resp) begin
                    state_d = pick(1'b0, req_b, streak_q);
                end
            end
            ST_SERVE_B: begin
                if (mem_resp) begin
                    state_d = pick(req_a, 1'b0, streak_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_SERVE_A && state_q != ST_SERVE_A) begin
            streak_d = 4'd0;
        end else if (state_d == ST_SERVE_B && state_q != ST_SERVE_B && req_a &&
                     streak_q < STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // State and streak registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // Downstream mux and response routing, decoded from the registered state only.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        mem_wmask   = '0;
        resp_a      = 1'b0;
        resp_b      = 1'b0;
        rdata_a     = '0;
        rdata_b     = '0;
        case (state_q)
            ST_SERVE_A: begin
                mem_read    = 1'b1;
                mem_address = address_a;
                resp_a      = mem_resp;
                rdata_a     = mem_rdata;
            end
            ST_SERVE_B: begin
                // A simultaneous read and write is treated as a write.
                mem_write   = write_b;
                mem_read    = read_b & ~write_b;
                mem_address = address_b;
                mem_wdata   = wdata_b;
                mem_wmask   = MASK_W'(wmask_b);
                resp_b      = mem_resp;
                rdata_b     = mem_rdata;
            end
            default: begin
                mem_read = 1'b0;
            end
        endcase
    end

    assign grant_a = (state_q == ST_SERVE_A);
    assign grant_b = (state_q == ST_SERVE_B);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a reference model of who owns the memory port.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int MASK_W = DATA_W / 8;
    localparam int MAXS   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              read_a;
    logic [ADDR_W-1:0] address_a;
    logic              resp_a;
    logic [DATA_W-1:0] rdata_a;
    logic              read_b;
    logic              write_b;
    logic [ADDR_W-1:0] address_b;
    logic [DATA_W-1:0] wdata_b;
    logic [MASK_W-1:0] wmask_b;
    logic              resp_b;
    logic [DATA_W-1:0] rdata_b;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp;
    logic [DATA_W-1:0] mem_rdata;
    logic              grant_a;
    logic              grant_b;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_B_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write_b(write_b), .address_b(address_b),
        .wdata_b(wdata_b), .wmask_b(wmask_b), .resp_b(resp_b), .rdata_b(rdata_b),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .grant_a(grant_a), .grant_b(grant_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: owner of the port (0 nobody, 1 fetch, 2 MEM) and the
    // number of contested B wins since A was last granted.
    int m_owner  = 0;
    int m_streak = 0;
    int n_owner  = 0;
    int n_streak = 0;
    bit last_resp_a = 1'b0;
    bit last_resp_b = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input bit ra, input bit rb, input int s);
        if (ra && rb) return (s == MAXS) ? 1 : 2;
        if (ra) return 1;
        if (rb) return 2;
        return 0;
    endfunction

    task automatic check_outputs();
        bit          ra;
        bit          rb;
        logic [31:0] e_addr;
        ra = read_a;
        rb = read_b | write_b;
        e_addr = (m_owner == 1) ? 32'(address_a) : (m_owner == 2) ? 32'(address_b) : 32'd0;
        chk("grant_a", 32'(grant_a), 32'(m_owner == 1));
        chk("grant_b", 32'(grant_b), 32'(m_owner == 2));
        chk("mem_read", 32'(mem_read),
            32'((m_owner == 1) || (m_owner == 2 && read_b && !write_b)));
        chk("mem_write", 32'(mem_write), 32'(m_owner == 2 && write_b));
        chk("mem_address", 32'(mem_address), e_addr);
        chk("mem_wmask", 32'(mem_wmask), (m_owner == 2) ? 32'(wmask_b) : 32'd0);
        if (m_owner != 1)
            chk("mem_wdata", 32'(mem_wdata), (m_owner == 2) ? 32'(wdata_b) : 32'd0);
        chk("resp_a", 32'(resp_a), 32'(m_owner == 1 && mem_resp));
        chk("resp_b", 32'(resp_b), 32'(m_owner == 2 && mem_resp));
        if (m_owner == 1 && mem_resp) chk("rdata_a", 32'(rdata_a), 32'(mem_rdata));
        if (m_owner == 2 && mem_resp) chk("rdata_b", 32'(rdata_b), 32'(mem_rdata));
        if (!rst_n) begin
            chk("rst_rdata_a", 32'(rdata_a), 32'd0);
            chk("rst_rdata_b", 32'(rdata_b), 32'd0);
        end

        // Who owns the port next cycle.
        if (m_owner == 0)      n_owner = winner(ra, rb, m_streak);
        else if (!mem_resp)    n_owner = m_owner;
        else if (m_owner == 1) n_owner = winner(1'b0, rb, m_streak);
        else                   n_owner = winner(ra, 1'b0, m_streak);
        n_streak = m_streak;
        if (n_owner == 1 && m_owner != 1) n_streak = 0;
        else if (n_owner == 2 && m_owner != 2 && ra && m_streak < MAXS) n_streak = m_streak + 1;
    endtask

    // One clock cycle: inputs already driven just after the falling edge.
    task automatic step();
        #1;
        if (!rst_n) begin
            m_owner  = 0;
            m_streak = 0;
        end
        check_outputs();
        last_resp_a = resp_a;
        last_resp_b = resp_b;
        @(posedge clk);
        if (rst_n) begin
            m_owner  = n_owner;
            m_streak = n_streak;
        end else begin
            m_owner  = 0;
            m_streak = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        int kind;
        rst_n = 1'b0;
        read_a = 1'b0; address_a = '0;
        read_b = 1'b0; write_b = 1'b0; address_b = '0; wdata_b = '0; wmask_b = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Lone fetch read: strobe one cycle after the request, data returned with resp.
        read_a = 1'b1; address_a = 16'h3000;
        chk("t2_idle_mem_read", 32'(mem_read), 32'd0);
        step();
        chk("t2_mem_read", 32'(mem_read), 32'd1);
        chk("t2_mem_address", 32'(mem_address), 32'h3000);
        step();
        step();
        mem_resp = 1'b1; mem_rdata = 16'h1234;
        #1;
        chk("t2_resp_a", 32'(resp_a), 32'd1);
        chk("t2_rdata_a", 32'(rdata_a), 32'h1234);
        step();
        read_a = 1'b0; mem_resp = 1'b0;
        chk("t2_resp_a_pulse", 32'(resp_a), 32'd0);
        step();

        // Reset in the middle of a MEM write abandons it.
        write_b = 1'b1; address_b = 16'h0100; wdata_b = 16'h5555; wmask_b = 2'b11;
        step();
        chk("t1_grant_b", 32'(grant_b), 32'd1);
        mem_resp = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_resp_b", 32'(resp_b), 32'd0);
        chk("t1_rst_mem_write", 32'(mem_write), 32'd0);
        step();
        step();
        rst_n = 1'b1; write_b = 1'b0; mem_resp = 1'b0;
        step();
        chk("t1_after_grant_b", 32'(grant_b), 32'd0);

        // Tie from IDLE: B first, then A with no idle cycle in between.
        read_a = 1'b1; address_a = 16'h2002;
        write_b = 1'b1; address_b = 16'h0200; wdata_b = 16'h0F0F; wmask_b = 2'b01;
        step();
        chk("t3_b_first", 32'(grant_b), 32'd1);
        mem_resp = 1'b1;
        step();
        write_b = 1'b0;
        chk("t3_a_no_bubble", 32'(grant_a), 32'd1);
        step();
        read_a = 1'b0; mem_resp = 1'b0;
        step();

        // Starvation bound: four contested B wins, then A is forced.
        for (int k = 0; k < 5; k++) begin
            read_a = 1'b1; address_a = 16'(16'h4000 + k);
            write_b = 1'b1; address_b = 16'(16'h0300 + k);
            step();
            if (k < MAXS) begin
                chk("t4_b_grant", 32'(grant_b), 32'd1);
                read_a = 1'b0; mem_resp = 1'b1;
                step();
                write_b = 1'b0; mem_resp = 1'b0;
                step();
            end else begin
                chk("t4_forced_a", 32'(grant_a), 32'd1);
                mem_resp = 1'b1;
                step();
                read_a = 1'b0;
                chk("t4_then_b", 32'(grant_b), 32'd1);
                step();
                write_b = 1'b0; mem_resp = 1'b0;
                step();
            end
        end

        // Masked write.
        write_b = 1'b1; address_b = 16'h0042; wdata_b = 16'hAB00; wmask_b = 2'b10;
        step();
        chk("t5_mem_write", 32'(mem_write), 32'd1);
        chk("t5_mem_read", 32'(mem_read), 32'd0);
        chk("t5_mem_wmask", 32'(mem_wmask), 32'h2);
        chk("t5_mem_wdata", 32'(mem_wdata), 32'hAB00);
        mem_resp = 1'b1;
        step();
        write_b = 1'b0; mem_resp = 1'b0;
        step();

        // Stray completion in IDLE, then read+write together issues only the write.
        mem_resp = 1'b1;
        #1;
        chk("t6_stray_resp_a", 32'(resp_a), 32'd0);
        chk("t6_stray_resp_b", 32'(resp_b), 32'd0);
        step();
        mem_resp = 1'b0;
        read_b = 1'b1; write_b = 1'b1; address_b = 16'h0777;
        step();
        chk("t6_write_only", 32'(mem_write), 32'd1);
        chk("t6_no_read", 32'(mem_read), 32'd0);
        mem_resp = 1'b1;
        step();
        read_b = 1'b0; write_b = 1'b0; mem_resp = 1'b0;
        step();

        // Randomized traffic; fetch occasionally withdraws while waiting so the
        // streak counter gets pushed towards its limit.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (read_a) begin
                if (last_resp_a) begin
                    read_a = ($urandom % 2) == 1;
                    address_a = 16'($urandom);
                end else if (m_owner != 1 && ($urandom % 12) == 0) begin
                    read_a = 1'b0;
                end
            end else if (($urandom % 3) == 0) begin
                read_a = 1'b1;
                address_a = 16'($urandom);
            end
            if (!(read_b || write_b) || last_resp_b) begin
                if (($urandom % 2) == 0) begin
                    kind = int'($urandom % 8);
                    write_b = (kind < 4) || (kind == 7);
                    read_b = (kind >= 4);
                    address_b = 16'($urandom);
                    wdata_b = 16'($urandom);
                    wmask_b = 2'($urandom);
                end else begin
                    read_b = 1'b0;
                    write_b = 1'b0;
                end
            end
            mem_resp = ($urandom % 3) == 0;
            mem_rdata = 16'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
